key_expansion: RTL
==================

KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 The block SHALL have no parameters; key size is selected at run time by switch.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port clk, input, 1 bit: rising-edge clock.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port key, input, 256 bits: cipher key, MSB-aligned; 128-bit key in [255:128], 192-bit key in [255:64], 256-bit key in [255:0].
REQ-006 Port switch, input, 2 bits: key size; 00 = 128-bit (Nk=4, Nr=10); 01 = 192-bit (Nk=6, Nr=12); 10 or 11 = 256-bit (Nk=8, Nr=14).
REQ-007 Port start, input, 1 bit: request expansion; sampled only in IDLE.
REQ-008 Port key_d, output, 1920 bits: expanded schedule; word w[i] at key_d[1919-32*i -:32]; round key r at key_d[1919-128*r -:128].
REQ-009 Port busy, output, 1 bit: high in LOAD and GEN.
REQ-010 Port done, output, 1 bit: one-cycle pulse when the schedule is complete.
REQ-011 Port key_valid, output, 1 bit: high from done until the next accepted start or reset.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, GEN and DONE; busy and done SHALL be decoded from state only.
REQ-013 In IDLE with start=1, the block SHALL latch key and switch, clear key_d and key_valid, and go to LOAD.
REQ-014 In LOAD, the block SHALL write w[0..Nk-1] from the latched key in one cycle, set i=Nk, and go to GEN.
REQ-015 In GEN, the block SHALL write exactly one word w[i] per cycle, for i = Nk .. 4*(Nr+1)-1 (44/52/60 words total).
REQ-016 Word rule: temp = w[i-1].
  - If i mod Nk = 0: temp = SubWord(RotWord(temp)) xor {Rcon[i/Nk],24'h0}.
  - Else if Nk = 8 and i mod 8 = 4: temp = SubWord(temp).
  - Then w[i] = w[i-Nk] xor temp.
REQ-017 i mod Nk and i/Nk SHALL be tracked with a modulo-Nk phase counter and an Rcon index counter; no dividers.
REQ-018 After the last word is written, the FSM SHALL enter DONE; done=1 for exactly that cycle; key_valid SHALL set; the FSM SHALL return to IDLE.
REQ-019 Latency: done SHALL be high in the cycle following start-sample edge + 41 / 47 / 53 edges for 128 / 192 / 256-bit keys.
REQ-020 key_d words at index >= 4*(Nr+1) SHALL read zero.
REQ-021 start SHALL be ignored in LOAD, GEN and DONE; key and switch changes while busy SHALL NOT affect the result.
REQ-022 start held high continuously SHALL restart expansion on each return to IDLE.

Reset
REQ-023 rst=1 SHALL force IDLE and clear key_d to zero, key_valid=0, done=0, busy=0, and all counters, in any state including mid-GEN.
REQ-024 rst SHALL take priority over start in the same cycle.

Structure
REQ-025 A shared package SHALL hold the Rcon table (01,02,04,08,10,20,40,80,1b,36), the Nk/Nr/word-count constants per switch code, and the FSM state encoding.
REQ-026 One sub-module, sub_word, SHALL hold four forward S-box lookups (32-bit combinational); the forward S-box is a new table, not the decrypt path's inverse table.

Verification
REQ-027 Case 128-bit: switch=00, key=2b7e1516 28aed2a6 abf71588 09cf4f3c.
  - Required: w[4]=a0fafe17 and w[43]=b6630ca6.
  - done exactly 41 edges after start; key_d[159:0]=0.
REQ-028 Case 192-bit: switch=01, key=8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b.
  - Required: w[6]=fe0c91f7 and w[51]=01002202.
  - done after 47 edges.
REQ-029 Case 256-bit: switch=10, key=603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4.
  - Required: w[8]=9ba35411 and w[59]=706c631e.
  - done after 53 edges; switch=11 SHALL give identical results.
REQ-030 Case reset mid-GEN: assert rst at edge 20 of the 128-bit run.
  - Required next cycle: key_d=0, busy=0, key_valid=0, no done pulse.
  - A fresh start SHALL then reproduce REQ-027.
REQ-031 Case start/switch while busy: pulse start and flip switch to 10 during GEN of the 128-bit run.
  - Required: single done at edge 41, REQ-027 values, no second run.

Source files
------------

// File: rtl/key_expansion_pkg.sv
// Shared constants for the AES key schedule: FSM states, round constants and
// the per-key-size Nk / Nr / word-count lookup.
package key_expansion_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    GEN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int KEY_W     = 256;
  localparam int SCHED_W   = 1920;
  localparam int MAX_WORDS = 60;

  // Switch codes 10 and 11 both select the 256-bit schedule.
  function automatic logic [5:0] nk_of(input logic [1:0] sw);
    case (sw)
      2'b00:   return 6'd4;
      2'b01:   return 6'd6;
      default: return 6'd8;
    endcase
  endfunction

  function automatic logic [5:0] nr_of(input logic [1:0] sw);
    case (sw)
      2'b00:   return 6'd10;
      2'b01:   return 6'd12;
      default: return 6'd14;
    endcase
  endfunction

  function automatic logic [5:0] words_of(input logic [1:0] sw);
    return 6'((nr_of(sw) + 6'd1) << 2);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/key_expansion_sub_word.sv
// Forward AES S-box applied to each byte of a 32-bit word (purely combinational).
module sub_word (
  input  logic [31:0] word,
  output logic [31:0] sub
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at bits [8*(255-b) +: 8], and 255-b is simply ~b.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  assign sub = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};

endmodule

// File: rtl/key_expansion.sv
// AES key expansion for 128/192/256-bit keys, generating one schedule word per
// cycle into a 60-word register file exposed as a flat 1920-bit bus.
module key_expansion
  import key_expansion_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KEY_W-1:0]     key,
  input  logic [1:0]           switch,
  input  logic                 start,
  output logic [SCHED_W-1:0]   key_d,
  output logic                 busy,
  output logic                 done,
  output logic                 key_valid
);

  state_t state, next_state;

  logic [KEY_W-1:0] key_q;
  logic [1:0]       switch_q;
  logic [5:0]       idx;
  logic [2:0]       phase;
  logic [3:0]       rcon_idx;
  logic [31:0]      words [MAX_WORDS];

  logic [5:0]  nk;
  logic [5:0]  total;
  logic        last_word;
  logic        phase_wrap;
  logic [31:0] prev;
  logic [31:0] back;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp;
  logic [31:0] new_word;

  assign nk         = nk_of(switch_q);
  assign total      = words_of(switch_q);
  assign last_word  = (idx == total - 6'd1);
  assign phase_wrap = ({3'b000, phase} == nk - 6'd1);

  assign busy = (state == LOAD) || (state == GEN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD;
      LOAD:    next_state = GEN;
      GEN:     if (last_word) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // phase tracks i mod Nk; rcon_idx tracks i/Nk for the Rcon lookup.
  always_comb begin
    prev   = words[idx - 6'd1];
    back   = words[idx - nk];
    sub_in = (phase == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    temp   = prev;
    if (phase == 3'd0)
      temp = sub_out ^ {rcon(rcon_idx), 24'h000000};
    else if (nk == 6'd8 && phase == 3'd4)
      temp = sub_out;
    new_word = back ^ temp;
  end

  sub_word u_sub_word (
    .word (sub_in),
    .sub  (sub_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q     <= '0;
      switch_q  <= '0;
      idx       <= '0;
      phase     <= '0;
      rcon_idx  <= '0;
      key_valid <= 1'b0;
      for (int k = 0; k < MAX_WORDS; k++) words[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            key_q     <= key;
            switch_q  <= switch;
            key_valid <= 1'b0;
            for (int k = 0; k < MAX_WORDS; k++) words[k] <= '0;
          end
        end
        LOAD: begin
          for (int k = 0; k < 8; k++)
            if (6'(k) < nk) words[k] <= key_q[KEY_W-1-32*k -: 32];
          idx      <= nk;
          phase    <= '0;
          rcon_idx <= 4'd1;
        end
        GEN: begin
          words[idx] <= new_word;
          idx        <= idx + 6'd1;
          if (phase_wrap) begin
            phase    <= '0;
            rcon_idx <= rcon_idx + 4'd1;
          end else begin
            phase    <= phase + 3'd1;
          end
          if (last_word) key_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < MAX_WORDS; g++) begin : g_flat
    assign key_d[SCHED_W-1-32*g -: 32] = words[g];
  end

endmodule
